// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory command and error pulse.
// The arbiter binds to the slave modport; requesters/memory models bind to master.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port: data priority with
// fetch starvation override, bounded wait for mem_ack with error abort.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        start;
    logic        pick_d;

    logic        owner_d_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        timeout_q;
    logic [3:0]  starve_q;
    logic [7:0]  wait_q;
    logic        if_gnt_q;
    logic        d_gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Fetch only overrides data when it is actually requesting and has been starved.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        pick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req || bus.if_req) begin
                    state_d = ACCESS;
                    start   = 1'b1;
                    pick_d  = bus.d_req && !(bus.if_req && starve_q == STARVE_LIM);
                end
            end
            ACCESS: begin
                if (bus.mem_ack || wait_q == WAIT_LAST) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            starve_q  <= '0;
            wait_q    <= '0;
            if_gnt_q  <= 1'b0;
            d_gnt_q   <= 1'b0;
        end else begin
            if_gnt_q <= 1'b0;
            d_gnt_q  <= 1'b0;
            if (start) begin
                owner_d_q <= pick_d;
                if_gnt_q  <= !pick_d;
                d_gnt_q   <= pick_d;
                we_q      <= pick_d & bus.d_we;
                addr_q    <= pick_d ? bus.d_addr : bus.if_addr;
                wdata_q   <= pick_d ? bus.d_wdata : '0;
                wait_q    <= '0;
                timeout_q <= 1'b0;
                if (!pick_d)
                    starve_q <= '0;
                else if (bus.if_req && starve_q != STARVE_LIM)
                    starve_q <= starve_q + 4'd1;
            end
            // Ack in the final allowed cycle wins over the abort.
            if (state_q == ACCESS) begin
                if (bus.mem_ack) begin
                    rdata_q <= we_q ? '0 : bus.mem_rdata;
                end else begin
                    wait_q <= wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        rdata_q   <= 32'hDEADBEEF;
                        timeout_q <= 1'b1;
                    end
                end
            end
        end
    end

    logic in_access;
    logic in_resp;
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign bus.mem_req   = in_access;
    assign bus.mem_we    = in_access & we_q;
    assign bus.mem_addr  = in_access ? addr_q  : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = in_resp & !owner_d_q;
    assign bus.d_rvalid  = in_resp &  owner_d_q;
    assign bus.if_rdata  = (in_resp && !owner_d_q) ? rdata_q : '0;
    assign bus.d_rdata   = (in_resp &&  owner_d_q) ? rdata_q : '0;
    assign bus.err       = in_resp & timeout_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, consecutive fetch losses that force a fetch grant (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles waiting for mem_ack before abort (1..255).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  fetch port request, held until if_gnt.
REQ-006 SHALL have port if_addr  input  32  fetch word address.
REQ-007 SHALL have port if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 SHALL have port if_rvalid  output  1  one-cycle pulse: if_rdata valid.
REQ-009 SHALL have port if_rdata  output  32  fetched instruction.
REQ-010 SHALL have port d_req  input  1  data port request, held until d_gnt.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  32  data address.
REQ-013 SHALL have port d_wdata  input  32  store data.
REQ-014 SHALL have port d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 SHALL have port d_rvalid  output  1  one-cycle pulse: load data valid or store complete.
REQ-016 SHALL have port d_rdata  output  32  load data (0 for stores).
REQ-017 SHALL have ports mem_req/mem_we/mem_addr/mem_wdata  output  1/1/32/32  shared memory command.
REQ-018 SHALL have ports mem_ack/mem_rdata  input  1/32  memory completion and read data.
REQ-019 SHALL have port err  output  1  one-cycle pulse on timeout abort.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-021 IDLE: if d_req or if_req, SHALL select winner, latch its addr/we/wdata (fetch: we=0, wdata=0), pulse that port's gnt next cycle, go to ACCESS; else stay IDLE.
REQ-022 Priority SHALL be data over fetch, except fetch wins when starve_cnt == STARVE_MAX.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) when both requests present and data wins; SHALL clear when fetch is granted; unchanged otherwise.
REQ-024 ACCESS: mem_req SHALL be 1 with latched command stable every cycle until mem_ack sampled 1.
REQ-025 On mem_ack in ACCESS, SHALL capture mem_rdata (forced 0 for stores) and go to RESP.
REQ-026 RESP: SHALL pulse owner's rvalid for exactly one cycle with captured data, then return to IDLE; no new grant issued in RESP.
REQ-027 Minimum request-to-rvalid latency SHALL be 3 cycles (grant edge, ack in first ACCESS cycle, RESP); back-to-back accesses SHALL be separated by one IDLE cycle.
REQ-028 mem_req SHALL be 0 in IDLE and RESP; gnt/rvalid/err never asserted to both ports in same cycle.
REQ-029 Wait counter SHALL clear on ACCESS entry, increment each ACCESS cycle without mem_ack; at count TIMEOUT without ack, SHALL drop mem_req, pulse err, go to RESP returning rdata 32'hDEADBEEF.
REQ-030 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (no err).
REQ-031 mem_ack outside ACCESS SHALL be ignored.
REQ-032 Requests deasserted before gnt SHALL be dropped without side effects; request inputs are ignored outside IDLE.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, starve_cnt 0, wait counter 0, all latched command/data registers 0.
REQ-034 During and after reset all outputs SHALL be 0 (gnt, rvalid, err, mem_req, mem_we, addresses, data).
REQ-035 Reset asserted mid-ACCESS SHALL abort the access with no rvalid or err pulse; first grant possible on the first rising edge after rst_n releases.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x40, mem_ack one cycle after mem_req rises with mem_rdata=0x00000013 -> if_gnt pulse, mem_addr=0x40, if_rvalid pulse with if_rdata=0x13, d_* outputs stay 0.
REQ-037 Simultaneous: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xA5 -> data granted first, mem_we=1, d_rvalid with d_rdata=0; fetch granted on following IDLE.
REQ-038 Starvation: d_req and if_req held continuously, STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F.
REQ-039 Timeout: mem_ack held 0, TIMEOUT=15 -> mem_req high 15 cycles then drops, err pulse, rvalid with 0xDEADBEEF, FSM back in IDLE.
REQ-040 Reset mid-access: rst_n low during ACCESS -> mem_req=0 immediately, no rvalid/err; after release, pending if_req granted normally.
REQ-041 Stray ack: mem_ack=1 in IDLE -> no rvalid, no state change.
